// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters: ALU/CSR (req0) and the load unit (req1). Arbitration is
//   round-robin. The block also keeps a per-register pending-write scoreboard
//   that decode uses to detect RAW hazards.
//
// Optional feature (compile-time macro RF_WB_FWD_EN):
//   When defined, the block adds o_fwd_rs1/o_fwd_rs2/o_fwd_data. A source
//   register that is being written in the current cycle is reported as not
//   busy and its value is forwarded from the registered write data.
//   When undefined, a source register stays busy through its write cycle.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_req0_valid/rd/data         ALU writeback request
//   o_req0_ready                 ALU request accepted this cycle
//   i_req1_valid/rd/data         load writeback request
//   o_req1_ready                 load request accepted this cycle
//   i_issue_valid, i_issue_rd    decode issued an instruction writing rd
//   i_flush                      pipeline flush, clears all pending bits
//   i_rs1, i_rs2                 decode source registers to check
//   o_busy_rs1, o_busy_rs2       source has a pending write (combinational)
//   o_fwd_rs1/rs2, o_fwd_data    forwarding outputs (RF_WB_FWD_EN only)
//   o_rf_we/waddr/wdata          registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  input  logic [4:0]      i_req0_rd,
  input  logic [XLEN-1:0] i_req0_data,
  output logic            o_req0_ready,
  input  logic            i_req1_valid,
  input  logic [4:0]      i_req1_rd,
  input  logic [XLEN-1:0] i_req1_data,
  output logic            o_req1_ready,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic            i_flush,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic            o_busy_rs1,
  output logic            o_busy_rs2,
`ifdef RF_WB_FWD_EN
  output logic            o_fwd_rs1,
  output logic            o_fwd_rs2,
  output logic [XLEN-1:0] o_fwd_data,
`endif
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata
);

  // lastGrant_q = 1 means req1 was granted last, so req0 wins the next tie.
  logic            lastGrant_q, lastGrant_d;
  logic            grant0, grant1, accept;
  logic [4:0]      selRd;
  logic [XLEN-1:0] selData;

  logic            rfWe_q, rfWe_d;
  logic [4:0]      rfWaddr_q, rfWaddr_d;
  logic [XLEN-1:0] rfWdata_q, rfWdata_d;

  logic [NREGS-1:0] pending_q, pending_d;

  // Round-robin grant; never grants while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_rst) begin
      if (i_req0_valid && (!i_req1_valid || lastGrant_q)) grant0 = 1'b1;
      if (i_req1_valid && (!i_req0_valid || !lastGrant_q)) grant1 = 1'b1;
    end
  end

  assign accept       = grant0 | grant1;
  assign selRd        = grant1 ? i_req1_rd   : i_req0_rd;
  assign selData      = grant1 ? i_req1_data : i_req0_data;
  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // Next-state for the pointer and the write port. An accepted write to x0
  // is consumed but never reaches the register file.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grant0) lastGrant_d = 1'b0;
    else if (grant1) lastGrant_d = 1'b1;

    rfWe_d    = accept && (selRd != 5'd0);
    rfWaddr_d = rfWaddr_q;
    rfWdata_d = rfWdata_q;
    if (accept) begin
      rfWaddr_d = selRd;
      rfWdata_d = selData;
    end
  end

  // Scoreboard next-state: flush (or retiring write) clears first, then a
  // new issue sets, so a re-issue of the register being written keeps it busy.
  always_comb begin
    pending_d = pending_q;
    if (i_flush) begin
      pending_d = '0;
    end else if (rfWe_q) begin
      pending_d[rfWaddr_q] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != 5'd0)) begin
      pending_d[i_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lastGrant_q <= 1'b1;
      rfWe_q      <= 1'b0;
      rfWaddr_q   <= 5'd0;
      rfWdata_q   <= '0;
      pending_q   <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      rfWe_q      <= rfWe_d;
      rfWaddr_q   <= rfWaddr_d;
      rfWdata_q   <= rfWdata_d;
      pending_q   <= pending_d;
    end
  end

  assign o_rf_we    = rfWe_q;
  assign o_rf_waddr = rfWaddr_q;
  assign o_rf_wdata = rfWdata_q;

`ifdef RF_WB_FWD_EN
  logic hitRs1, hitRs2;

  // A source being written this cycle is served from the write data.
  assign hitRs1     = rfWe_q && (rfWaddr_q == i_rs1) && (i_rs1 != 5'd0);
  assign hitRs2     = rfWe_q && (rfWaddr_q == i_rs2) && (i_rs2 != 5'd0);
  assign o_busy_rs1 = pending_q[i_rs1] && !hitRs1;
  assign o_busy_rs2 = pending_q[i_rs2] && !hitRs2;
  assign o_fwd_rs1  = hitRs1;
  assign o_fwd_rs2  = hitRs2;
  assign o_fwd_data = rfWdata_q;
`else
  assign o_busy_rs1 = pending_q[i_rs1];
  assign o_busy_rs2 = pending_q[i_rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Each cycle's inputs are driven just
// after the rising edge; outputs are checked 1ns later against a small
// reference model. Accepted writes are pushed to a queue and popped when the
// register-file write strobe is due. Honours RF_WB_FWD_EN like the design.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            v0, v1, iv, fl;
  logic [4:0]      rd0, rd1, ird, rs1, rs2;
  logic [XLEN-1:0] d0, d1;
  logic            ready0, ready1, busy1, busy2, we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
`ifdef RF_WB_FWD_EN
  logic            fwd1, fwd2;
  logic [XLEN-1:0] fwdData;
`endif

  regfile_wb_arbiter #(.NREGS(32), .XLEN(XLEN)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v0),
    .i_req0_rd    (rd0),
    .i_req0_data  (d0),
    .o_req0_ready (ready0),
    .i_req1_valid (v1),
    .i_req1_rd    (rd1),
    .i_req1_data  (d1),
    .o_req1_ready (ready1),
    .i_issue_valid(iv),
    .i_issue_rd   (ird),
    .i_flush      (fl),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_busy_rs1   (busy1),
    .o_busy_rs2   (busy2),
`ifdef RF_WB_FWD_EN
    .o_fwd_rs1    (fwd1),
    .o_fwd_rs2    (fwd2),
    .o_fwd_data   (fwdData),
`endif
    .o_rf_we      (we),
    .o_rf_waddr   (waddr),
    .o_rf_wdata   (wdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [36:0] sbQueue[$];
  logic        mLastGrant;
  logic [31:0] mPending;
  logic        mWe;
  logic [4:0]  curAddr;
  logic [31:0] curData;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r, input logic a0v, input logic [4:0] a0rd, input logic [31:0] a0d,
    input logic a1v, input logic [4:0] a1rd, input logic [31:0] a1d,
    input logic isv, input logic [4:0] isrd, input logic flush,
    input logic [4:0] s1, input logic [4:0] s2);
    rst = r;   v0 = a0v; rd0 = a0rd; d0 = a0d;
    v1 = a1v;  rd1 = a1rd; d1 = a1d;
    iv = isv;  ird = isrd; fl = flush;
    rs1 = s1;  rs2 = s2;
  endtask

  // Checks the current cycle against the model, then advances the model
  // across the next rising edge.
  task automatic checkOutput();
    logic        g0, g1, nextWe, hit1, hit2, nextLast;
    logic [36:0] entry;
    logic [31:0] nextPend;
    logic [4:0]  selRd;
    logic [31:0] selData;
    #1;
    g0 = !rst && v0 && (!v1 || mLastGrant);
    g1 = !rst && v1 && (!v0 || !mLastGrant);
    checkVal("ready0", {31'd0, ready0}, {31'd0, g0});
    checkVal("ready1", {31'd0, ready1}, {31'd0, g1});
    checkVal("rf_we", {31'd0, we}, {31'd0, mWe});
    if (mWe) begin
      checkVal("sb_nonempty", {31'd0, sbQueue.size() != 0}, 32'd1);
      if (sbQueue.size() != 0) begin
        entry   = sbQueue.pop_front();
        curAddr = entry[36:32];
        curData = entry[31:0];
        checkVal("rf_waddr", {27'd0, waddr}, {27'd0, curAddr});
        checkVal("rf_wdata", wdata, curData);
      end
    end
    hit1 = mWe && (curAddr == rs1) && (rs1 != 5'd0);
    hit2 = mWe && (curAddr == rs2) && (rs2 != 5'd0);
`ifdef RF_WB_FWD_EN
    checkVal("busy_rs1", {31'd0, busy1}, {31'd0, mPending[rs1] && !hit1});
    checkVal("busy_rs2", {31'd0, busy2}, {31'd0, mPending[rs2] && !hit2});
    checkVal("fwd_rs1", {31'd0, fwd1}, {31'd0, hit1});
    checkVal("fwd_rs2", {31'd0, fwd2}, {31'd0, hit2});
    if (hit1 || hit2) checkVal("fwd_data", fwdData, curData);
`else
    checkVal("busy_rs1", {31'd0, busy1}, {31'd0, mPending[rs1]});
    checkVal("busy_rs2", {31'd0, busy2}, {31'd0, mPending[rs2]});
`endif
    selRd   = g1 ? rd1 : rd0;
    selData = g1 ? d1 : d0;
    if (rst) begin
      nextWe   = 1'b0;
      nextPend = 32'd0;
      nextLast = 1'b1;
    end else begin
      nextWe = (g0 || g1) && (selRd != 5'd0);
      if (nextWe) sbQueue.push_back({selRd, selData});
      nextPend = mPending;
      if (fl) nextPend = 32'd0;
      else if (mWe) nextPend[curAddr] = 1'b0;
      if (iv && ird != 5'd0) nextPend[ird] = 1'b1;
      nextLast = g0 ? 1'b0 : (g1 ? 1'b1 : mLastGrant);
    end
    @(posedge clk);
    #1;
    mWe        = nextWe;
    mPending   = nextPend;
    mLastGrant = nextLast;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mWe = 1'b0; mPending = 32'd0; mLastGrant = 1'b1;
    curAddr = 5'd0; curData = 32'd0;

    // Reset held two cycles with requests present: nothing is granted.
    applyStimulus(1, 1, 5'd5, 32'h1, 1, 5'd4, 32'h2, 1, 5'd6, 0, 5'd5, 5'd31); checkOutput();
    applyStimulus(1, 1, 5'd5, 32'h1, 1, 5'd4, 32'h2, 1, 5'd6, 0, 5'd6, 5'd31); checkOutput();

    // Conflict: req0 first, then the held req1; repeat shows req0 wins again.
    applyStimulus(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, 0, 5'd3, 5'd4); checkOutput();
    applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h22, 0, 0, 0, 5'd3, 5'd4); checkOutput();
    applyStimulus(0, 1, 5'd10, 32'h33, 1, 5'd11, 32'h44, 0, 0, 0, 5'd3, 5'd4); checkOutput();
    applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd11, 32'h44, 0, 0, 0, 5'd10, 5'd11); checkOutput();

    // Single request and its one-cycle write latency, then an idle cycle.
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0); checkOutput();

    // Scoreboard: issue rd7, load writes rd7, busy clears after the write.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'hCAFE0007, 0, 0, 0, 5'd7, 5'd7); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7); checkOutput();

    // Re-issue of rd7 in its write cycle keeps it busy.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h70707070, 0, 0, 0, 5'd7, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0); checkOutput();

    // x0: accepted but never written, never busy.
    applyStimulus(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 5'd0, 0, 5'd0, 5'd0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7); checkOutput();

    // Flush with pending {2,9,31} plus issue rd9; a request in the flush
    // cycle still writes.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0, 5'd2, 5'd9); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd2, 5'd9); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd31, 0, 5'd2, 5'd9); checkOutput();
    applyStimulus(0, 1, 5'd12, 32'h12121212, 0, 0, 0, 1, 5'd9, 1, 5'd2, 5'd31); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd2); checkOutput();

    // Reset during a write cycle drops the following write.
    applyStimulus(0, 1, 5'd13, 32'h13131313, 0, 0, 0, 0, 0, 0, 5'd31, 5'd7); checkOutput();
    applyStimulus(1, 1, 5'd14, 32'h14141414, 0, 0, 0, 0, 0, 0, 5'd13, 5'd9); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd13); checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
